// File: rtl/sersub_pkg.sv
// Shared types for the bit-serial subtractor: FSM state encoding and counter sizing.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package sersub_pkg;

    // Two-bit encoding; the unused code falls back to idle in the FSM.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bit counter width: enough to count W-1, never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/fullsubs.sv
// One-bit full subtractor cell: diff = x - y - bin, bout = borrow out.
// Latency: combinational.
// Backpressure: none.
module fullsubs (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic diff,
    output logic bout
);

    assign diff = x ^ y ^ bin;
    assign bout = (~x & y) | (~x & bin) | (y & bin);

endmodule

// File: rtl/serial_subs_ctrl.sv
// Bit-serial W-bit subtractor (diff = a - b mod 2^W), one fullsubs cell stepped LSB-first.
// Latency: accept edge 0 -> done pulse during cycle W+1; one op per W+2 cycles.
// Backpressure: start taken only while ready (idle); start at other times is dropped.
// Build option SERSUB_CHAIN_EN adds chain_in: the held borrow feeds the next op (multi-word).
module serial_subs_ctrl
    import sersub_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
`ifdef SERSUB_CHAIN_EN
    input  logic         chain_in,
`endif
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         ready,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] diff,
    output logic         bout
);

    localparam int            CW       = cnt_width(W);
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [W-1:0]  a_sr;
    logic [W-1:0]  b_sr;
    logic [W-1:0]  res_sr;
    logic [W-1:0]  res_nxt;
    logic          borrow;
    logic          cell_diff;
    logic          cell_bout;
    logic          accept;
    logic          last;
    logic          init_borrow;

    fullsubs u_cell (
        .x    (a_sr[0]),
        .y    (b_sr[0]),
        .bin  (borrow),
        .diff (cell_diff),
        .bout (cell_bout)
    );

    // Result register fills from the top so the first (LS) bit ends up at bit 0.
    generate
        if (W == 1) begin : g_res_one
            assign res_nxt = cell_diff;
        end else begin : g_res_wide
            assign res_nxt = {cell_diff, res_sr[W-1:1]};
        end
    endgenerate

`ifdef SERSUB_CHAIN_EN
    // Previous word's final borrow seeds this word when chaining is requested.
    assign init_borrow = chain_in & bout;
`else
    assign init_borrow = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and status decode.
    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        last      = 1'b0;
        case (state)
            ST_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (cnt == CNT_LAST) begin
                    last      = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Operand capture, serial shifting, borrow chain and result hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            cnt    <= '0;
            borrow <= 1'b0;
            diff   <= '0;
            bout   <= 1'b0;
        end else if (accept) begin
            a_sr   <= a;
            b_sr   <= b;
            cnt    <= '0;
            borrow <= init_borrow;
        end else if (busy) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            res_sr <= res_nxt;
            borrow <= cell_bout;
            cnt    <= cnt + CW'(1);
            // Outputs load on the last bit so they are stable for the whole done cycle.
            if (last) begin
                diff <= res_nxt;
                bout <= cell_bout;
            end
        end
    end

endmodule
